// File: rtl/pose_score_combiner.sv
// Collects per-limb DTW scores as each limb pipeline finishes, then folds the
// enabled, captured scores into one frame score (sum, weighted sum, max or min).
module pose_score_combiner #(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned SCORE_W  = 32,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned TIMEOUT  = 65536
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [N_CH*SCORE_W-1:0]  ch_score,
  input  logic [N_CH-1:0]          ch_done,
  input  logic [N_CH-1:0]          ch_enable,
  input  logic [N_CH*WEIGHT_W-1:0] weight,
  input  logic [1:0]               mode,
  output logic [OUT_W-1:0]         score,
  output logic                     done,
  output logic                     timed_out,
  output logic                     overrun,
  output logic                     busy,
  output logic [N_CH-1:0]          ch_captured
);

  localparam int unsigned PROD_W = SCORE_W + WEIGHT_W;
  localparam int unsigned SUM_W  = ((OUT_W > PROD_W) ? OUT_W : PROD_W) + 1;
  localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned TC_W   = $clog2(TIMEOUT);

  localparam logic [1:0] MODE_SUM  = 2'd0;
  localparam logic [1:0] MODE_WSUM = 2'd1;
  localparam logic [1:0] MODE_MAX  = 2'd2;

  localparam logic [OUT_W-1:0] OUT_MAX = {OUT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ACCUM   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic                   timeout_hit;

  logic [SCORE_W-1:0]     cap_score [N_CH];
  logic [TC_W-1:0]        tcnt;
  logic                   to_flag;
  logic [IDX_W-1:0]       idx;
  logic [OUT_W-1:0]       acc;
  logic [1:0]             mode_q;
  logic [N_CH*WEIGHT_W-1:0] weight_q;
  logic [N_CH-1:0]        en_q;

  logic [N_CH-1:0]        cap_base;
  logic [N_CH-1:0]        qual;
  logic [N_CH-1:0]        cap_next;
  logic                   covered;
  logic                   tc_last;

  logic [SCORE_W-1:0]     cur_score;
  logic [WEIGHT_W-1:0]    cur_weight;
  logic                   cur_on;
  logic [PROD_W-1:0]      product;
  logic [SUM_W-1:0]       sum;
  logic [OUT_W-1:0]       acc_step;

  // A new frame starts from an empty capture set; dones only count in IDLE/COLLECT.
  always_comb begin
    cap_base = (state == IDLE) ? '0 : ch_captured;
    qual     = '0;
    if (state == IDLE || state == COLLECT) begin
      qual = ch_done & ch_enable & ~cap_base;
    end
    cap_next = cap_base | qual;
    covered  = ((cap_next & ch_enable) == ch_enable);
    tc_last  = (tcnt == TC_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (|qual) begin
            next_state = covered ? ACCUM : COLLECT;
          end
        end
        COLLECT: begin
          if (covered) begin
            next_state = ACCUM;
          end else if (tc_last) begin
            next_state  = ACCUM;
            timeout_hit = 1'b1;
          end
        end
        ACCUM: begin
          if (idx == IDX_W'(N_CH - 1)) begin
            next_state = DONE;
          end
        end
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // One channel folded per cycle; sums clamp at the output full-scale value.
  always_comb begin
    cur_score  = '0;
    cur_weight = '0;
    cur_on     = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (idx == IDX_W'(i)) begin
        cur_score  = cap_score[i];
        cur_weight = weight_q[i*WEIGHT_W +: WEIGHT_W];
        cur_on     = en_q[i] & ch_captured[i];
      end
    end
    product  = PROD_W'(cur_score) * PROD_W'(cur_weight);
    sum      = SUM_W'(acc) + ((mode_q == MODE_WSUM) ? SUM_W'(product) : SUM_W'(cur_score));
    acc_step = acc;
    if (cur_on) begin
      case (mode_q)
        MODE_SUM, MODE_WSUM: acc_step = (sum > SUM_W'(OUT_MAX)) ? OUT_MAX : OUT_W'(sum);
        MODE_MAX: begin
          if (OUT_W'(cur_score) > acc) acc_step = OUT_W'(cur_score);
        end
        default: begin
          if (OUT_W'(cur_score) < acc) acc_step = OUT_W'(cur_score);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score       <= '0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      overrun     <= 1'b0;
      ch_captured <= '0;
      tcnt        <= '0;
      to_flag     <= 1'b0;
      idx         <= '0;
      acc         <= '0;
      mode_q      <= '0;
      weight_q    <= '0;
      en_q        <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        cap_score[i] <= '0;
      end
    end else if (clear) begin
      done        <= 1'b0;
      timed_out   <= 1'b0;
      overrun     <= 1'b0;
      ch_captured <= '0;
    end else begin
      done <= (state == DONE);

      if (state == IDLE || state == COLLECT) begin
        if (state == COLLECT || (|qual)) begin
          ch_captured <= cap_next;
        end
        for (int i = 0; i < int'(N_CH); i++) begin
          if (qual[i]) begin
            cap_score[i] <= ch_score[i*SCORE_W +: SCORE_W];
          end
        end
      end

      if (state == IDLE) begin
        tcnt <= '0;
      end else if (state == COLLECT) begin
        tcnt <= tcnt + TC_W'(1);
      end

      // Mode, weights and enables are frozen for the whole accumulation pass.
      if (next_state == ACCUM && state != ACCUM) begin
        idx      <= '0;
        mode_q   <= mode;
        weight_q <= weight;
        en_q     <= ch_enable;
        to_flag  <= timeout_hit;
        acc      <= (mode == 2'd3) ? OUT_MAX : '0;
      end else if (state == ACCUM) begin
        idx <= idx + IDX_W'(1);
        acc <= acc_step;
        if (next_state == DONE) begin
          score     <= acc_step;
          timed_out <= to_flag;
        end
      end

      if ((state == ACCUM || state == DONE) && (|(ch_done & ch_enable))) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pose_score_combiner.sv
// Randomised and directed frames for pose_score_combiner, checked against a
// frame-level model (capture window, timeout and combine rules as arithmetic).
module tb_pose_score_combiner;

  localparam int unsigned N_CH     = 3;
  localparam int unsigned SCORE_W  = 8;
  localparam int unsigned WEIGHT_W = 4;
  localparam int unsigned OUT_W    = 8;
  localparam int unsigned TIMEOUT  = 16;
  localparam int          NEVER    = 1000;
  localparam longint      OUT_MAX  = (64'sd1 <<< OUT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     clear;
  logic [N_CH*SCORE_W-1:0]  ch_score;
  logic [N_CH-1:0]          ch_done;
  logic [N_CH-1:0]          ch_enable;
  logic [N_CH*WEIGHT_W-1:0] weight;
  logic [1:0]               mode;
  logic [OUT_W-1:0]         score;
  logic                     done;
  logic                     timed_out;
  logic                     overrun;
  logic                     busy;
  logic [N_CH-1:0]          ch_captured;

  always #5 clk = ~clk;

  pose_score_combiner #(
    .N_CH(N_CH), .SCORE_W(SCORE_W), .WEIGHT_W(WEIGHT_W),
    .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ch_score(ch_score),
    .ch_done(ch_done), .ch_enable(ch_enable), .weight(weight), .mode(mode),
    .score(score), .done(done), .timed_out(timed_out), .overrun(overrun),
    .busy(busy), .ch_captured(ch_captured)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Frame description: per-channel enable, weight, score and done offset (cycle index).
  int     f_mode;
  int     f_en  [N_CH];
  int     f_w   [N_CH];
  int     f_s   [N_CH];
  int     f_off [N_CH];
  int     x_ch, x_off, x_val;
  bit     ovr_exp = 1'b0;
  longint last_score = 0;

  // x_kind: 0 none, 1 random duplicate, 2 random late done, 3 x_* preset by caller.
  task automatic run_frame(input string tag, input int x_kind, input longint lit);
    int t0, tc, e, done_edge, first_done;
    bit to;
    longint acc;
    logic [N_CH-1:0] cap;
    int cand[$];

    t0 = NEVER;
    tc = 0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (f_en[i] != 0) begin
        if (f_off[i] < t0) t0 = f_off[i];
        if (f_off[i] > tc) tc = f_off[i];
      end
    end
    if (tc > t0 + int'(TIMEOUT)) begin
      e  = t0 + int'(TIMEOUT);
      to = 1'b1;
    end else begin
      e  = tc;
      to = 1'b0;
    end

    if (x_kind == 0) begin
      x_off = -1;
    end else if (x_kind == 1) begin
      for (int i = 0; i < int'(N_CH); i++)
        if (f_en[i] != 0 && f_off[i] < e) cand.push_back(i);
      if (cand.size() == 0) begin
        x_off = -1;
      end else begin
        x_ch  = cand[$urandom_range(0, cand.size() - 1)];
        x_off = $urandom_range(f_off[x_ch] + 1, e);
        x_val = $urandom_range(0, 255);
      end
    end else if (x_kind == 2) begin
      x_ch  = $urandom_range(0, N_CH - 1);
      x_off = $urandom_range(e + 1, e + int'(N_CH) + 1);
      x_val = $urandom_range(0, 255);
    end

    cap = '0;
    acc = (f_mode == 3) ? OUT_MAX : 0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (f_en[i] != 0 && f_off[i] <= e) begin
        cap[i] = 1'b1;
        case (f_mode)
          0: acc += f_s[i];
          1: acc += f_s[i] * f_w[i];
          2: if (f_s[i] > acc) acc = f_s[i];
          default: if (f_s[i] < acc) acc = f_s[i];
        endcase
      end
    end
    if (acc > OUT_MAX) acc = OUT_MAX;
    if (x_off > e && x_off <= e + int'(N_CH) + 1 && f_en[x_ch] != 0) ovr_exp = 1'b1;
    done_edge = e + int'(N_CH) + 1;

    for (int i = 0; i < int'(N_CH); i++) begin
      ch_enable[i] = (f_en[i] != 0);
      weight[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(f_w[i]);
    end
    mode = 2'(f_mode);
    first_done = -1;

    for (int k = 0; k <= done_edge + 1; k++) begin
      ch_done = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        ch_score[i*SCORE_W +: SCORE_W] = SCORE_W'($urandom);
        if (f_off[i] == k) begin
          ch_done[i] = 1'b1;
          ch_score[i*SCORE_W +: SCORE_W] = SCORE_W'(f_s[i]);
        end
      end
      if (x_off == k) begin
        ch_done[x_ch] = 1'b1;
        ch_score[x_ch*SCORE_W +: SCORE_W] = SCORE_W'(x_val);
      end
      if (k > e) begin
        mode   = 2'($urandom);
        weight = (N_CH*WEIGHT_W)'($urandom);
      end
      @(posedge clk);
      #1;
      if (done === 1'b1 && first_done < 0) first_done = k;
      if (k == e) check({tag, ".busy"}, 64'(busy), 64'd1);
      if (k == done_edge + 1) check({tag, ".done_width"}, 64'(done), 64'd0);
      @(negedge clk);
    end
    ch_done = '0;

    check({tag, ".latency"}, 64'(first_done), 64'(done_edge));
    check({tag, ".score"}, 64'(score), 64'(acc));
    check({tag, ".timed_out"}, 64'(timed_out), 64'(to));
    check({tag, ".captured"}, 64'(ch_captured), 64'(cap));
    check({tag, ".overrun"}, 64'(overrun), 64'(ovr_exp));
    if (lit >= 0) check({tag, ".literal"}, 64'(score), 64'(lit));
    last_score = acc;
  endtask

  task automatic set_frame(input int m, input int en2, input int en1, input int en0,
                           input int s0, input int s1, input int s2,
                           input int o0, input int o1, input int o2);
    f_mode = m;
    f_en[0] = en0; f_en[1] = en1; f_en[2] = en2;
    f_s[0] = s0;   f_s[1] = s1;   f_s[2] = s2;
    f_off[0] = o0; f_off[1] = o1; f_off[2] = o2;
    f_w[0] = 1;    f_w[1] = 2;    f_w[2] = 3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    longint held;
    int j;
    bit seen;

    rst_n = 1'b0; clear = 1'b0; ch_done = '0; ch_score = '0;
    ch_enable = '0; weight = '0; mode = '0;
    repeat (2) @(negedge clk);
    check("reset.score", 64'(score), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.captured", 64'(ch_captured), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // No enabled channel: dones never qualify.
    ch_enable = '0; ch_done = '1;
    @(posedge clk); #1; ch_done = '0;
    @(negedge clk);
    check("noenable.busy", 64'(busy), 64'd0);

    set_frame(0, 1, 1, 1, 10, 20, 30, 0, 0, 0);
    run_frame("sum_same", 0, 60);

    set_frame(1, 1, 1, 1, 10, 20, 30, 0, 5, 10);
    x_ch = 0; x_off = 3; x_val = 99;
    run_frame("wsum_stagger_dup", 3, 140);

    set_frame(0, 1, 1, 1, 7, 8, 0, 0, 2, NEVER);
    run_frame("timeout", 0, 15);

    set_frame(0, 1, 1, 1, 200, 100, 50, 0, 0, 0);
    run_frame("saturate", 0, 255);

    set_frame(2, 1, 0, 1, 40, 5, 9, 0, 0, 0);
    run_frame("max_masked", 0, 40);
    set_frame(3, 1, 0, 1, 40, 5, 9, 0, 0, 0);
    run_frame("min_masked", 0, 9);

    set_frame(0, 1, 1, 1, 1, 2, 3, 0, 0, 0);
    x_ch = 1; x_off = 2; x_val = 77;
    run_frame("overrun", 3, 6);

    // Asynchronous reset in the middle of accumulation.
    ch_enable = '1; mode = 2'd0; ch_done = '1; ch_score = '1;
    @(posedge clk); #1; ch_done = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset.score", 64'(score), 64'd0);
    check("midreset.done", 64'(done), 64'd0);
    check("midreset.timed_out", 64'(timed_out), 64'd0);
    check("midreset.overrun", 64'(overrun), 64'd0);
    check("midreset.busy", 64'(busy), 64'd0);
    check("midreset.captured", 64'(ch_captured), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ovr_exp = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      f_mode = $urandom_range(0, 3);
      for (int i = 0; i < int'(N_CH); i++) begin
        f_en[i]  = ($urandom_range(0, 3) != 0) ? 1 : 0;
        f_w[i]   = $urandom_range(0, 15);
        f_s[i]   = $urandom_range(0, 255);
        f_off[i] = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, 12);
      end
      j = $urandom_range(0, N_CH - 1);
      f_en[j] = 1;
      if (f_off[j] == NEVER) f_off[j] = $urandom_range(0, 12);
      run_frame($sformatf("rand%0d", n), $urandom_range(0, 2), -1);
    end

    // Timed-out frame with a late done, so clear has status to wipe.
    set_frame(0, 1, 1, 1, 11, 22, 0, 0, 1, NEVER);
    x_ch = 0; x_off = int'(TIMEOUT) + 1; x_val = 5;
    run_frame("pre_clear", 3, 33);
    held = last_score;

    ch_enable = '1; mode = 2'd0; ch_done = 3'b001; ch_score = '1;
    @(posedge clk); #1; ch_done = '0;
    repeat (2) @(posedge clk);
    #1;
    check("clear.busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    check("clear.busy", 64'(busy), 64'd0);
    check("clear.timed_out", 64'(timed_out), 64'd0);
    check("clear.overrun", 64'(overrun), 64'd0);
    check("clear.captured", 64'(ch_captured), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    check("clear.no_done", 64'(seen), 64'd0);
    check("clear.score_held", 64'(score), 64'(held));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pose_score_combiner.md
Name: pose_score_combiner

Overview:
Parametrised successor to the fixed three-limb score stage. Collects per-channel DTW scores from N_CH limb pipelines. The dones may arrive at different cycles; the block does not need them to be simultaneous. It applies a per-channel enable mask and one of four combine modes, then emits one frame-sequence score with a done pulse. A collection timeout stops a stalled limb pipeline from hanging the top level.

Parameters:
N_CH, 3, number of limb channels (>=1)
SCORE_W, 32, width of each unsigned channel score
WEIGHT_W, 4, width of each unsigned per-channel weight
OUT_W, 32, width of combined score (>= SCORE_W)
TIMEOUT, 65536, max cycles spent in COLLECT before forced completion (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
clear  in  1  synchronous abort; returns to IDLE, clears status
ch_score  in  N_CH*SCORE_W  channel i score at bits [i*SCORE_W +: SCORE_W]
ch_done  in  N_CH  single-cycle pulse; ch_score slice valid in same cycle
ch_enable  in  N_CH  1 = channel participates in frame
weight  in  N_CH*WEIGHT_W  channel i weight, used in mode 1
mode  in  2  0 sum, 1 weighted sum, 2 max, 3 min
score  out  OUT_W  combined score, held until next done
done  out  1  one-cycle pulse, score valid
timed_out  out  1  qualifies done: frame completed by timeout
overrun  out  1  sticky: ch_done dropped in ACCUM/DONE
busy  out  1  high in COLLECT, ACCUM, DONE
ch_captured  out  N_CH  channels captured in current or last frame

Behaviour:
- Reset (rst_n low, async): all outputs 0, state IDLE, all capture registers, counters and accumulator 0.
- clear takes priority over all other inputs except rst_n. Effects: next state IDLE; done=0; timed_out=0; overrun=0; ch_captured=0. score keeps its last value.
- Capture: in IDLE or COLLECT, ch_done[i] & ch_enable[i] latches the slice into cap_score[i] and sets ch_captured[i].
  - A repeated done on an already-captured channel is ignored; the first value is kept.
  - A done on a disabled channel is ignored.
- IDLE -> COLLECT: on the first qualifying done.
  - ch_captured is cleared, then the new capture is applied.
  - The timeout counter loads 0.
- COLLECT -> ACCUM: on the edge where (ch_captured | qualifying ch_done) covers ch_enable. This is evaluated against ch_enable sampled that cycle. If a single edge covers every enabled channel, the block goes IDLE -> ACCUM directly.
- COLLECT timeout: the counter increments each cycle. At TIMEOUT-1 the block moves to ACCUM and sets an internal to_flag.
- ACCUM:
  - mode and weight are sampled on entry.
  - One channel per cycle, index 0..N_CH-1, so N_CH cycles.
  - Only channels that are both captured and enabled contribute.
- Combine modes:
  - Mode 0: acc += cap.
  - Mode 1: acc += cap*weight; the product is SCORE_W+WEIGHT_W bits.
  - Mode 2: acc = max over contributors.
  - Mode 3: acc = min over contributors; the accumulator initialises to all-ones.
  - Modes 0/1 saturate at 2^OUT_W-1 and stay saturated.
- ACCUM -> DONE after index N_CH-1. On that transition score <= acc and timed_out <= to_flag.
- DONE: done=1 for exactly one cycle, then IDLE. timed_out holds until the next done or clear.
- Latency: done is high in the cycle after edge E+N_CH+1, where E is the edge that samples the final required ch_done. For N_CH=3 that is 4 cycles.
- Overrun: a qualifying ch_done in ACCUM or DONE is dropped and sets overrun (sticky until clear or reset).
- ch_enable all zero: no done qualifies; the block stays IDLE.
- Changes to ch_enable during COLLECT take effect on the completion test from the next edge.
- busy = (state != IDLE).

Test Plan:
- Mode 0, all enabled, ch_score=10/20/30 with dones in the same cycle -> score=60, done pulse exactly 4 cycles later, timed_out=0, ch_captured=3'b111.
- Mode 1, weights 1/2/3, scores 10/20/30 with dones staggered 5 cycles apart, plus a duplicate ch_done[0] carrying 99 -> score=140; done 4 cycles after ch2's done; the duplicate is ignored.
- TIMEOUT=16, ch2 never completes, scores 7/8 -> done with score=15, timed_out=1, ch_captured=3'b011, 16 cycles after entering COLLECT.
- Mode 0, OUT_W=SCORE_W=8, scores 200/100/50 -> score=255 (saturated).
- Mode 2 then mode 3, ch_enable=3'b101, scores 40/5/9 -> score=40, then score=9; ch1 never affects the result.
- ch_done pulse during ACCUM -> overrun=1 and the frame result is unchanged. Then assert rst_n low mid-ACCUM -> all outputs 0 immediately. Then assert clear mid-COLLECT -> IDLE, no done, score keeps its previous value.
